// File: rtl/sr2cb_m_phy_rx_pre.sv
// rtl/sr2cb_m_phy_rx_pre.sv - RX preamble/SFD checker and stripper with registered payload stream
// Optional statistics counters: define SR2CB_PHY_RX_PRE_STATS_EN
module sr2cb_m_phy_rx_pre #(
    parameter int MIN_PREAMBLE = 5,
    parameter int MAX_PREAMBLE = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_d,
    input  logic        rx_dv,
    output logic [7:0]  tx_d,
    output logic        tx_dv,
    output logic        tx_sof,
    output logic        tx_eof,
`ifdef SR2CB_PHY_RX_PRE_STATS_EN
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
`endif
    output logic        pre_err
);

    localparam logic [7:0] PRE_BYTE = 8'h55;
    localparam logic [7:0] SFD_BYTE = 8'hD5;
    localparam logic [3:0] MIN_P    = 4'(MIN_PREAMBLE);
    localparam logic [3:0] MAX_P    = 4'(MAX_PREAMBLE);

    typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;

    state_t      state_q, state_d;
    logic [3:0]  pre_cnt_q, pre_cnt_d;
    logic [7:0]  hold_q, hold_d;
    logic        hold_vld_q, hold_vld_d;
    logic        first_q, first_d;
    logic [7:0]  tx_d_d;
    logic        tx_dv_d, tx_sof_d, tx_eof_d, pre_err_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= DROP;
            pre_cnt_q  <= '0;
            hold_q     <= '0;
            hold_vld_q <= 1'b0;
            first_q    <= 1'b0;
            tx_d       <= '0;
            tx_dv      <= 1'b0;
            tx_sof     <= 1'b0;
            tx_eof     <= 1'b0;
            pre_err    <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            first_q    <= first_d;
            tx_d       <= tx_d_d;
            tx_dv      <= tx_dv_d;
            tx_sof     <= tx_sof_d;
            tx_eof     <= tx_eof_d;
            pre_err    <= pre_err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        first_d    = first_q;
        tx_d_d     = tx_d;
        tx_dv_d    = 1'b0;
        tx_sof_d   = 1'b0;
        tx_eof_d   = 1'b0;
        pre_err_d  = 1'b0;
        case (state_q)
            IDLE: begin
                hold_vld_d = 1'b0;
                if (rx_dv) begin
                    if (rx_d == PRE_BYTE) begin
                        state_d   = PRE;
                        pre_cnt_d = 4'd1;
                    end else begin
                        state_d   = DROP;
                        pre_err_d = 1'b1;
                    end
                end
            end
            PRE: begin
                if (!rx_dv) begin
                    state_d   = IDLE;
                    pre_err_d = 1'b1;
                end else if (rx_d == PRE_BYTE && pre_cnt_q < MAX_P) begin
                    pre_cnt_d = pre_cnt_q + 4'd1;
                end else if (rx_d == SFD_BYTE && pre_cnt_q >= MIN_P) begin
                    state_d    = DATA;
                    first_d    = 1'b1;
                    hold_vld_d = 1'b0;
                end else begin
                    state_d   = DROP;
                    pre_err_d = 1'b1;
                end
            end
            DATA: begin
                // One-byte hold lets the last byte carry eof once rx_dv drops.
                if (rx_dv) begin
                    hold_d     = rx_d;
                    hold_vld_d = 1'b1;
                    if (hold_vld_q) begin
                        tx_d_d   = hold_q;
                        tx_dv_d  = 1'b1;
                        tx_sof_d = first_q;
                        first_d  = 1'b0;
                    end
                end else if (hold_vld_q) begin
                    tx_d_d     = hold_q;
                    tx_dv_d    = 1'b1;
                    tx_sof_d   = first_q;
                    tx_eof_d   = 1'b1;
                    first_d    = 1'b0;
                    hold_vld_d = 1'b0;
                    state_d    = IDLE;
                end else begin
                    pre_err_d = 1'b1;
                    first_d   = 1'b0;
                    state_d   = IDLE;
                end
            end
            DROP: begin
                if (!rx_dv) state_d = IDLE;
            end
            default: state_d = DROP;
        endcase
    end

`ifdef SR2CB_PHY_RX_PRE_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            if (tx_dv && tx_eof) frame_cnt <= frame_cnt + 16'd1;
            if (pre_err)         err_cnt   <= err_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sr2cb_m_phy_rx_pre.sv
// tb/tb_sr2cb_m_phy_rx_pre.sv - directed self-checking bench for sr2cb_m_phy_rx_pre
module tb_sr2cb_m_phy_rx_pre;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_d = 8'h00;
    logic       rx_dv = 1'b0;
    logic [7:0] tx_d;
    logic       tx_dv, tx_sof, tx_eof, pre_err;
`ifdef SR2CB_PHY_RX_PRE_STATS_EN
    logic [15:0] frame_cnt, err_cnt;
`endif

    always #5 clk = ~clk;

    sr2cb_m_phy_rx_pre #(.MIN_PREAMBLE(5), .MAX_PREAMBLE(7)) dut (
        .clk(clk), .rst_n(rst_n), .rx_d(rx_d), .rx_dv(rx_dv),
        .tx_d(tx_d), .tx_dv(tx_dv), .tx_sof(tx_sof), .tx_eof(tx_eof),
`ifdef SR2CB_PHY_RX_PRE_STATS_EN
        .frame_cnt(frame_cnt), .err_cnt(err_cnt),
`endif
        .pre_err(pre_err)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int errs = 0;
    int overlap = 0;
    logic [7:0] od[$];
    bit         osof[$];
    bit         oeof[$];
    int         ocyc[$];
    int         ecyc[$];
    int         pcyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (tx_dv) begin
            od.push_back(tx_d);
            osof.push_back(tx_sof);
            oeof.push_back(tx_eof);
            ocyc.push_back(cyc);
        end
        if (pre_err) begin
            errs++;
            ecyc.push_back(cyc);
        end
        if (pre_err && tx_dv) overlap++;
    end

    task automatic drive(input logic dv, input logic [7:0] d);
        @(negedge clk);
        rx_dv = dv;
        rx_d  = d;
    endtask

    task automatic send_pre(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 8'h55);
    endtask

    task automatic send_pay(input logic [7:0] d);
        drive(1'b1, d);
        pcyc.push_back(cyc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
    endtask

    task automatic clr;
        od.delete(); osof.delete(); oeof.delete(); ocyc.delete();
        ecyc.delete(); pcyc.delete();
        errs = 0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (tx_dv !== 1'b0 || tx_sof !== 1'b0 || tx_eof !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: dv=%b sof=%b eof=%b, want 0 0 0", tx_dv, tx_sof, tx_eof);
        end
        tests++;
        if (tx_d !== 8'h00 || pre_err !== 1'b0) begin
            fails++;
            $display("FAIL reset_data: tx_d=%h pre_err=%b, want 00 0", tx_d, pre_err);
        end
        rst_n = 1'b1;
        idle(3);
        clr();
    endtask

    task automatic test_good_frame;
        clr();
        send_pre(7);
        drive(1'b1, 8'hD5);
        send_pay(8'h01); send_pay(8'h02); send_pay(8'h03);
        idle(4);
        tests++;
        if (od.size() !== 3) begin
            fails++;
            $display("FAIL good_count: got %0d bytes, want 3", od.size());
        end
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (i >= od.size() || od[i] !== 8'(i + 1) || osof[i] !== (i == 0) ||
                oeof[i] !== (i == 2) || ocyc[i] !== pcyc[i] + 2) begin
                fails++;
                $display("FAIL good_byte%0d: got d=%h sof=%b eof=%b cyc=%0d, want d=%h sof=%b eof=%b cyc=%0d",
                         i, od[i], osof[i], oeof[i], ocyc[i], 8'(i + 1), i == 0, i == 2, pcyc[i] + 2);
            end
        end
        tests++;
        if (errs !== 0) begin
            fails++;
            $display("FAIL good_err: got %0d pre_err pulses, want 0", errs);
        end
    endtask

    task automatic test_preamble_limits;
        int d8;
        clr();
        send_pre(5);
        drive(1'b1, 8'hD5);
        send_pay(8'hAA);
        idle(3);
        tests++;
        if (od.size() !== 1 || od[0] !== 8'hAA || osof[0] !== 1'b1 || oeof[0] !== 1'b1 || errs !== 0) begin
            fails++;
            $display("FAIL pre_min: got n=%0d d=%h sof=%b eof=%b errs=%0d, want n=1 d=aa sof=1 eof=1 errs=0",
                     od.size(), od[0], osof[0], oeof[0], errs);
        end
        clr();
        send_pre(4);
        drive(1'b1, 8'hD5);
        drive(1'b1, 8'h11);
        idle(3);
        tests++;
        if (od.size() !== 0 || errs !== 1) begin
            fails++;
            $display("FAIL pre_short: got n=%0d errs=%0d, want n=0 errs=1", od.size(), errs);
        end
        clr();
        send_pre(7);
        drive(1'b1, 8'h55);
        d8 = cyc;
        drive(1'b1, 8'hD5);
        drive(1'b1, 8'h22);
        idle(3);
        tests++;
        if (od.size() !== 0 || errs !== 1 || ecyc[0] !== d8 + 1) begin
            fails++;
            $display("FAIL pre_long: got n=%0d errs=%0d err_cyc=%0d, want n=0 errs=1 err_cyc=%0d",
                     od.size(), errs, ecyc[0], d8 + 1);
        end
    endtask

    task automatic test_bad_bytes;
        clr();
        send_pre(7);
        drive(1'b1, 8'h5D);
        drive(1'b1, 8'h01); drive(1'b1, 8'h02);
        idle(3);
        tests++;
        if (od.size() !== 0 || errs !== 1) begin
            fails++;
            $display("FAIL bad_sfd: got n=%0d errs=%0d, want n=0 errs=1", od.size(), errs);
        end
        clr();
        drive(1'b1, 8'hAB);
        send_pre(3);
        drive(1'b1, 8'hD5);
        drive(1'b1, 8'h01);
        idle(3);
        tests++;
        if (od.size() !== 0 || errs !== 1) begin
            fails++;
            $display("FAIL bad_first: got n=%0d errs=%0d, want n=0 errs=1", od.size(), errs);
        end
        clr();
        send_pre(7);
        drive(1'b1, 8'hD5);
        idle(3);
        tests++;
        if (od.size() !== 0 || errs !== 1) begin
            fails++;
            $display("FAIL empty_frame: got n=%0d errs=%0d, want n=0 errs=1", od.size(), errs);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] e;
        clr();
        send_pre(7);
        drive(1'b1, 8'hD5);
        for (int i = 0; i < 4; i++) send_pay(8'h10 + 8'(i));
        drive(1'b0, 8'h00);
        send_pre(7);
        drive(1'b1, 8'hD5);
        for (int i = 0; i < 4; i++) send_pay(8'h20 + 8'(i));
        idle(4);
        tests++;
        if (od.size() !== 8 || errs !== 0) begin
            fails++;
            $display("FAIL b2b_count: got n=%0d errs=%0d, want n=8 errs=0", od.size(), errs);
        end
        for (int i = 0; i < 8; i++) begin
            e = 8'h10 + 8'((i / 4) * 16) + 8'(i % 4);
            tests++;
            if (i >= od.size() || od[i] !== e || osof[i] !== (i % 4 == 0) || oeof[i] !== (i % 4 == 3) ||
                ocyc[i] !== pcyc[i] + 2) begin
                fails++;
                $display("FAIL b2b_byte%0d: got d=%h sof=%b eof=%b, want d=%h sof=%b eof=%b",
                         i, od[i], osof[i], oeof[i], e, i % 4 == 0, i % 4 == 3);
            end
        end
    endtask

    task automatic test_reset_mid;
        clr();
        send_pre(7);
        drive(1'b1, 8'hD5);
        send_pay(8'h30); send_pay(8'h31);
        @(negedge clk);
        rst_n = 1'b0; rx_dv = 1'b1; rx_d = 8'h32;
        @(negedge clk);
        tests++;
        if (tx_dv !== 1'b0 || tx_d !== 8'h00 || tx_eof !== 1'b0 || tx_sof !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset_out: got dv=%b d=%h sof=%b eof=%b, want 0 00 0 0", tx_dv, tx_d, tx_sof, tx_eof);
        end
        rst_n = 1'b1; rx_d = 8'h33;
        for (int i = 4; i < 10; i++) drive(1'b1, 8'h30 + 8'(i));
        idle(3);
        tests++;
        if (od.size() !== 1 || od[0] !== 8'h30 || osof[0] !== 1'b1 || oeof[0] !== 1'b0 || errs !== 0) begin
            fails++;
            $display("FAIL mid_reset_drop: got n=%0d d=%h sof=%b eof=%b errs=%0d, want n=1 d=30 sof=1 eof=0 errs=0",
                     od.size(), od[0], osof[0], oeof[0], errs);
        end
        clr();
        send_pre(6);
        drive(1'b1, 8'hD5);
        send_pay(8'h40); send_pay(8'h41);
        idle(3);
        tests++;
        if (od.size() !== 2 || od[0] !== 8'h40 || osof[0] !== 1'b1 || oeof[0] !== 1'b0 ||
            od[1] !== 8'h41 || osof[1] !== 1'b0 || oeof[1] !== 1'b1 || errs !== 0) begin
            fails++;
            $display("FAIL mid_reset_next: got n=%0d d0=%h d1=%h errs=%0d, want n=2 d0=40 d1=41 errs=0",
                     od.size(), od[0], od[1], errs);
        end
    endtask

`ifdef SR2CB_PHY_RX_PRE_STATS_EN
    task automatic test_stats;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(2);
        for (int f = 0; f < 3; f++) begin
            send_pre(5);
            drive(1'b1, 8'hD5);
            drive(1'b1, 8'(f));
            drive(1'b0, 8'h00);
        end
        drive(1'b1, 8'h99);
        drive(1'b0, 8'h00);
        send_pre(2);
        drive(1'b1, 8'hD5);
        idle(4);
        tests++;
        if (frame_cnt !== 16'd3 || err_cnt !== 16'd2) begin
            fails++;
            $display("FAIL stats: got frame_cnt=%0d err_cnt=%0d, want 3 2", frame_cnt, err_cnt);
        end
    endtask
`endif

    task automatic test_no_overlap;
        tests++;
        if (overlap !== 0) begin
            fails++;
            $display("FAIL err_dv_overlap: got %0d cycles, want 0", overlap);
        end
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_preamble_limits();
        test_bad_bytes();
        test_back_to_back();
        test_reset_mid();
`ifdef SR2CB_PHY_RX_PRE_STATS_EN
        test_stats();
`endif
        test_no_overlap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, want finish before 2000000");
        $fatal(1, "timeout");
    end

endmodule
